// File: rtl/key_pulse_bank.sv
// key_pulse_bank: N independent raw inputs, each synchronised, debounced and
// turned into one-cycle event strobes. Per-channel mode selects rise, fall,
// both edges, or rise with auto-repeat while the input stays held.
`timescale 1ns/1ps

// One channel: 2-flop synchroniser, debounce, level/edge detect, repeat FSM.
module key_pulse_lane #(
    parameter int DEB_CYC = 16,
    parameter int REP_DLY = 1000,
    parameter int REP_PER = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_trig,
    input  logic [1:0] i_mode,
    output logic       o_level,
    output logic       o_pulse
);
    localparam int CW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [RW-1:0] RC_DLY  = RW'(REP_DLY);
    localparam logic [RW-1:0] RC_PER  = RW'(REP_PER);
    localparam logic [RW-1:0] RC_ONE  = RW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT} rpt_st_e;

    logic          r_s1, r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_level, r_level_d;
    logic          r_pulse;
    rpt_st_e       r_st, w_st_nxt;
    logic [RW-1:0] r_rc, w_rc_nxt;

    logic w_rise, w_fall, w_strike, w_rpt_en, w_pulse_nxt;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_trig;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after DEB_CYC consecutive differing samples;
    // any sample matching the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
            if (r_s2 != r_level) begin
                if (r_cnt == CNT_TOP) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign w_rise   = r_level & ~r_level_d;
    assign w_fall   = ~r_level & r_level_d;
    assign w_rpt_en = r_level && (i_mode == 2'b11);

    // Repeat FSM state and delay counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= ST_IDLE;
            r_rc <= '0;
        end else begin
            r_st <= w_st_nxt;
            r_rc <= w_rc_nxt;
        end
    end

    // Repeat next-state: release or leaving mode 11 aborts silently.
    always_comb begin
        w_st_nxt = r_st;
        w_rc_nxt = r_rc;
        w_strike = 1'b0;
        if (!w_rpt_en) begin
            w_st_nxt = ST_IDLE;
            w_rc_nxt = '0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_st_nxt = ST_HOLD;
                        w_rc_nxt = RC_ONE;
                    end
                end
                ST_HOLD: begin
                    if (r_rc == RC_DLY) begin
                        w_strike = 1'b1;
                        w_st_nxt = ST_RPT;
                        w_rc_nxt = RC_ONE;
                    end else begin
                        w_rc_nxt = r_rc + RC_ONE;
                    end
                end
                ST_RPT: begin
                    if (r_rc == RC_PER) begin
                        w_strike = 1'b1;
                        w_rc_nxt = RC_ONE;
                    end else begin
                        w_rc_nxt = r_rc + RC_ONE;
                    end
                end
                default: begin
                    w_st_nxt = ST_IDLE;
                    w_rc_nxt = '0;
                end
            endcase
        end
    end

    // Select which events produce a strobe for the current mode.
    always_comb begin
        w_pulse_nxt = 1'b0;
        case (i_mode)
            2'b00:   w_pulse_nxt = w_rise;
            2'b01:   w_pulse_nxt = w_fall;
            2'b10:   w_pulse_nxt = w_rise | w_fall;
            default: w_pulse_nxt = w_rise | w_strike;
        endcase
    end

    // Register the strobe so downstream sees a clean one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pulse <= 1'b0;
        else        r_pulse <= w_pulse_nxt;
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
endmodule

// Bank of N identical, fully independent channels.
module key_pulse_bank #(
    parameter int N       = 4,
    parameter int DEB_CYC = 16,
    parameter int REP_DLY = 1000,
    parameter int REP_PER = 200
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_trig,
    input  logic [2*N-1:0] mode,
    output logic [N-1:0]   level_out,
    output logic [N-1:0]   pulse_out
);
    for (genvar g = 0; g < N; g++) begin : g_lane
        key_pulse_lane #(
            .DEB_CYC(DEB_CYC),
            .REP_DLY(REP_DLY),
            .REP_PER(REP_PER)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_trig (in_trig[g]),
            .i_mode (mode[2*g +: 2]),
            .o_level(level_out[g]),
            .o_pulse(pulse_out[g])
        );
    end
endmodule

// File: tb/tb_key_pulse_bank.sv
// Bench for key_pulse_bank: scenario table, hand-written corner sequences,
// and randomized traffic, all checked against a cycle reference model.
`timescale 1ns/1ps

module tb_key_pulse_bank;
    localparam int N       = 4;
    localparam int DEB     = 4;
    localparam int REP_DLY = 20;
    localparam int REP_PER = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_trig = '0;
    logic [2*N-1:0] mode = '0;
    logic [N-1:0]   level_out, pulse_out;

    int total = 0;
    int bad   = 0;

    key_pulse_bank #(.N(N), .DEB_CYC(DEB), .REP_DLY(REP_DLY), .REP_PER(REP_PER)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_trig  (in_trig),
        .mode     (mode),
        .level_out(level_out),
        .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;

    // Reference model: level flips once the last DEB synchronised samples all
    // disagree with it; events are flips seen one edge later; repeats fire at
    // fixed offsets from the press edge while held in mode 11.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lvl, m_pulse, m_chg;
    int           m_rs[N];
    int           m_edge;

    task automatic model_reset();
        hist.delete();
        repeat (DEB + 2) hist.push_back('0);
        m_lvl = '0; m_pulse = '0; m_chg = '0; m_edge = 0;
        for (int c = 0; c < N; c++) m_rs[c] = -1;
    endtask

    task automatic model_step();
        logic [N-1:0] lvl_pre, nl, rise, fall, np;
        logic [1:0]   md;
        logic         diff_all, strike;
        int           sz, d;
        lvl_pre = m_lvl; nl = lvl_pre; np = '0; sz = hist.size();
        rise = m_chg & lvl_pre;
        fall = m_chg & ~lvl_pre;
        for (int c = 0; c < N; c++) begin
            diff_all = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (hist[sz-2-j][c] == lvl_pre[c]) diff_all = 1'b0;
            if (diff_all) nl[c] = ~lvl_pre[c];
            md = mode[2*c +: 2];
            strike = 1'b0;
            if (!lvl_pre[c] || md != 2'b11) m_rs[c] = -1;
            else begin
                if (m_rs[c] >= 0) begin
                    d = m_edge - m_rs[c];
                    strike = (d == REP_DLY) || (d > REP_DLY && ((d - REP_DLY) % REP_PER) == 0);
                end
                if (rise[c]) m_rs[c] = m_edge;
            end
            case (md)
                2'b00:   np[c] = rise[c];
                2'b01:   np[c] = fall[c];
                2'b10:   np[c] = rise[c] | fall[c];
                default: np[c] = rise[c] | strike;
            endcase
        end
        hist.push_back(in_trig);
        void'(hist.pop_front());
        m_chg = nl ^ lvl_pre; m_lvl = nl; m_pulse = np; m_edge++;
    endtask

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        total++;
        if ({level_out, pulse_out} !== {m_lvl, m_pulse}) begin
            bad++;
            $display("FAIL model edge=%0d: level=%b pulse=%b expected level=%b pulse=%b",
                     m_edge - 1, level_out, pulse_out, m_lvl, m_pulse);
        end
    endtask

    // One clock: model consumes the pre-edge inputs, outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_trig = '0;
        @(negedge clk);
        #1 check("reset_state", 32'({level_out, pulse_out}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int         ch;
        logic [1:0] md;
        int         hi;      // cycles input held high from E0
        int         len;     // cycles observed
        int         e_cnt;   // pulses expected on ch
        int         e_first; // edge index of first pulse (-1 none)
        int         e_last;  // edge index of last pulse
        int         e_lvl;   // edge at which level first reads 1 (-1 never)
    } vec_t;

    vec_t vt[5];

    initial begin
        int hold[N];
        int c, cnt, first, last, lvl, n3;

        vt[0] = '{0, 2'b00,  3, 20, 0, -1, -1, -1}; // glitch
        vt[1] = '{0, 2'b00, 20, 40, 1,  6,  6,  5}; // rise only
        vt[2] = '{1, 2'b01, 20, 40, 1, 26, 26,  5}; // fall only
        vt[3] = '{2, 2'b10, 20, 40, 2,  6, 26,  5}; // both edges
        vt[4] = '{3, 2'b11, 56, 90, 6,  6, 58,  5}; // auto-repeat

        model_reset();
        for (int v = 0; v < 5; v++) begin
            c = vt[v].ch;
            do_reset();
            mode = '0;
            mode[2*c +: 2] = vt[v].md;
            tick(); tick();
            cnt = 0; first = -1; last = -1; lvl = -1;
            for (int t = 0; t < vt[v].len; t++) begin
                in_trig[c] = (t < vt[v].hi);
                tick();
                if (pulse_out[c]) begin
                    cnt++;
                    if (first < 0) first = t;
                    last = t;
                end
                if (level_out[c] && lvl < 0) lvl = t;
            end
            check($sformatf("vec%0d_count", v), cnt, vt[v].e_cnt);
            check($sformatf("vec%0d_first", v), first, vt[v].e_first);
            check($sformatf("vec%0d_last", v), last, vt[v].e_last);
            check($sformatf("vec%0d_level_edge", v), lvl, vt[v].e_lvl);
        end

        // Parallel press; ch3 leaves mode 11 during HOLD and comes back.
        do_reset();
        mode = {2'b11, 2'b11, 2'b10, 2'b00};
        tick(); tick();
        n3 = 0;
        for (int t = 0; t < 41; t++) begin
            in_trig = '1;
            if (t == 11) mode[7:6] = 2'b00;
            if (t == 14) mode[7:6] = 2'b11;
            tick();
            if (t == 6) check("par_same_cycle", 32'(pulse_out), 32'hf);
            if (t > 6 && pulse_out[3]) n3++;
            if (t == 26) check("par_ch2_strike", 32'(pulse_out[2]), 1);
            if (t == 34) check("par_ch2_strike2", 32'(pulse_out[2]), 1);
        end
        check("par_ch3_no_repeat", n3, 0);

        // Asynchronous reset while ch3 is repeating, input kept high.
        do_reset();
        mode = 8'b11_00_00_00;
        tick(); tick();
        for (int t = 0; t <= 26; t++) begin
            in_trig[3] = 1'b1;
            tick();
        end
        check("rpt_strike_before_rst", 32'(pulse_out[3]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_level", 32'(level_out[3]), 0);
        check("rst_async_pulse", 32'(pulse_out[3]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cnt = 0; first = -1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (pulse_out[3]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
        check("post_rst_count", cnt, 1);
        check("post_rst_first", first, 6);

        // Randomized holds and glitches with occasional mode changes.
        do_reset();
        for (int k = 0; k < N; k++) hold[k] = $urandom_range(1, 40);
        for (int k = 0; k < 2500; k++) begin
            if (k % 97 == 0) mode = 8'($urandom());
            for (int ch = 0; ch < N; ch++) begin
                if (hold[ch] == 0) begin
                    in_trig[ch] = ~in_trig[ch];
                    hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
                end else begin
                    hold[ch]--;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_pulse_bank.md
# key_pulse_bank

Multi-channel successor to the single-bit edge-to-pulse block: N independent raw inputs (push-buttons, remote-control strobes) are synchronised, debounced, and converted into single-cycle pulses. Each channel has a selectable mode: rising, falling, both edges, or rising with auto-repeat while held. It sits between the board I/O and the control FSMs. Downstream logic sees only clean one-cycle `pulse_out` strobes and the debounced `level_out`.

## Interface
- `N`, 4: number of channels, ≥1.
- `DEB_CYC`, 16: consecutive stable samples required to accept a level change, ≥1.
- `REP_DLY`, 1000: cycles from the initial press pulse to the first repeat pulse (mode 11), ≥1.
- `REP_PER`, 200: cycles between subsequent repeat pulses, ≥1.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_trig`  in  N  raw, asynchronous channel inputs.
- `mode`  in  2N  per-channel mode, bits [2i+1:2i] for channel i. Modes: 00 rise, 01 fall, 10 both edges, 11 rise + auto-repeat. Synchronous to `clk`.
- `level_out`  out  N  debounced level per channel (registered).
- `pulse_out`  out  N  one-cycle event strobe per channel (registered).

## Operation
- Per channel, the pipeline is: 2-flop synchroniser (`s1`→`s2`), then debounce, then level register, then edge/repeat logic, then the `pulse_out` register.
- Debounce counter `cnt` is $clog2(DEB_CYC) bits wide, minimum 1. On each edge:
  - if `s2 != level_out`: when `cnt == DEB_CYC-1`, `level_out <= s2` and `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - else `cnt <= 0`.
  - Any return to the old level restarts the count.
- Edge detect uses `level_d`, the previous `level_out`. Rise is `level_out & ~level_d`. Fall is `~level_out & level_d`.
- `pulse_out` is set from the mode:
  - 00: rise.
  - 01: fall.
  - 10: rise | fall.
  - 11: rise | repeat strike.
- Repeat FSM per channel has states IDLE, HOLD, RPT, with counter `rc` sized for max(REP_DLY, REP_PER).
  - IDLE: on rise with mode 11, go to HOLD with `rc <= 1`.
  - HOLD: if `rc == REP_DLY`, strike, go to RPT, `rc <= 1`; else `rc++`.
  - RPT: if `rc == REP_PER`, strike, `rc <= 1`; else `rc++`.
  - From any state, `level_out == 0` or mode ≠ 11 forces IDLE and `rc <= 0`. A forced exit produces no strike.
  - Mode 11 emits no pulse on release.
- Mode changes take effect on the next edge. The debounce state is unaffected by mode.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle.

## Timing
- Reset values: all `s1`, `s2`, `cnt`, `level_out`, `level_d`, `rc`, `pulse_out` are 0, and the FSM is IDLE. Reset is effective immediately, asynchronously, mid-operation included.
- Latency: input stable from just before edge E0 gives `s2` at E1, `level_out` toggling at E(DEB_CYC+1), and `pulse_out` high for exactly the cycle following E(DEB_CYC+2).
- `pulse_out` is never high for two consecutive cycles from edges alone. The minimum gap is DEB_CYC cycles, because the level cannot re-toggle faster.
- Repeat timing: the first strike is REP_DLY cycles after the initial pulse, then every REP_PER cycles. A strike is never emitted on the edge where `level_out` has already fallen.
- Input high at reset release is treated as a press: it gives a rise pulse after DEB_CYC+2 edges.
- A glitch shorter than DEB_CYC stable samples produces no `level_out` change and no pulse.
- Counters never wrap: `cnt` saturates by clearing at DEB_CYC-1, and `rc` reloads at its terminal value.

## Test plan
Bench parameters: N=4, DEB_CYC=4, REP_DLY=20, REP_PER=8. Edge E0 is the first edge sampling the new input value.
- Glitch: ch0 mode 00, `in_trig[0]` high for 3 cycles then low. Required: `level_out[0]` stays 0 and `pulse_out[0]` stays 0 throughout.
- Rise: ch0 mode 00, input stays high. Required: `level_out[0]`=1 at E5, `pulse_out[0]`=1 only in the cycle after E6. Release then gives no pulse.
- Fall/both: ch1 mode 01 and ch2 mode 10 with the same press and release waveform. Required: ch1 gives one pulse 6 edges after release. ch2 gives two pulses, at E6 after press and at E6 after release.
- Repeat: ch3 mode 11, input high for 56 cycles. Required: pulses after E6, E26, E34, E42, E50, E58 (6 total), and none after release.
- Parallel plus mode switch: all channels pressed in the same cycle must pulse in the same cycle. Switching ch3 from 11 to 00 during HOLD must suppress all repeat strikes.
- Reset mid-repeat: drop `rst_n` while ch3 is in RPT. Required: `pulse_out` and `level_out` are 0 at once. After release with the input still high, exactly one rise pulse follows 6 edges later.
